// File: rtl/dsp_pkg.sv
// Shared DSP core constants and the fetch sequencer state encoding.
// Decode and the testbench import this too.
package dsp_pkg;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // Sequential successor; wraps 0xFFF -> 0x000 by truncation.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch port bundle: decode control in, instruction memory address/data, decode-facing outputs.
// The master side is the fetch sequencer; the slave side is decode plus instrmem.
interface instr_fetch_ctrl_if;
  import dsp_pkg::*;

  logic               start;
  logic               stall;
  logic               halt;
  logic               jump;
  logic [ADDR_W-1:0]  jump_addr;
  logic               loop_start;
  logic [ADDR_W-1:0]  loop_end_addr;
  logic [CNT_W-1:0]   loop_count;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               loop_active;
  logic               halted;

  modport master (
    input  start, stall, halt, jump, jump_addr,
    input  loop_start, loop_end_addr, loop_count,
    input  imem_instr,
    output imem_addr, instr, instr_pc, instr_valid, loop_active, halted
  );

  modport slave (
    output start, stall, halt, jump, jump_addr,
    output loop_start, loop_end_addr, loop_count,
    output imem_instr,
    input  imem_addr, instr, instr_pc, instr_valid, loop_active, halted
  );

endinterface

// File: rtl/loop_ctrl.sv
// Single-level zero-overhead hardware loop: holds body bounds and iterations left,
// and tells the PC mux when to branch back to the loop start.
module loop_ctrl
  import dsp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              arm_i,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] instr_pc_i,
  input  logic [ADDR_W-1:0] loop_end_addr_i,
  input  logic [CNT_W-1:0]  loop_count_i,
  output logic              wrap_take_o,
  output logic [ADDR_W-1:0] wrap_addr_o,
  output logic              loop_active_o
);

  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              active_q, active_d;
  logic              at_end;

  assign at_end        = active_q && (pc_i == end_q);
  assign wrap_take_o   = at_end && (remaining_q > CNT_W'(1));
  assign wrap_addr_o   = start_addr_q;
  assign loop_active_o = active_q;

  always_comb begin
    start_addr_d = start_addr_q;
    end_d        = end_q;
    remaining_d  = remaining_q;
    active_d     = active_q;
    if (clear_i) begin
      active_d = 1'b0;
    end else if (arm_i) begin
      // The body begins right after the instruction carrying the loop setup.
      start_addr_d = pc_inc(instr_pc_i);
      end_d        = loop_end_addr_i;
      remaining_d  = loop_count_i;
      active_d     = (loop_count_i != '0);
    end else if (advance_i && at_end) begin
      if (wrap_take_o) begin
        remaining_d = remaining_q - 1'b1;
      end else begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
    end else begin
      active_q <= active_d;
    end
  end

  // Bounds and count are only meaningful while active, so they carry no reset.
  always_ff @(posedge clk) begin
    start_addr_q <= start_addr_d;
    end_q        <= end_d;
    remaining_q  <= remaining_d;
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Program sequencer: owns the PC, drives the instrmem address and presents each
// fetched instruction to decode with its address and a valid flag.
module instr_fetch_ctrl
  import dsp_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  instr_fetch_ctrl_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              instr_valid_q;
  logic [ADDR_W-1:0] imem_addr;
  logic              issue_valid;

  logic              run;
  logic              advance;
  logic              loop_arm;
  logic              loop_clear;
  logic              wrap_take;
  logic [ADDR_W-1:0] wrap_addr;
  logic              loop_active;

  assign run        = (state_q == ST_RUN);
  assign advance    = run && !bus.stall && !bus.halt && !bus.jump;
  assign loop_clear = run && !bus.stall && !bus.halt && bus.jump;
  assign loop_arm   = run && !bus.stall && !bus.halt && !bus.jump
                      && bus.loop_start && instr_valid_q;

  loop_ctrl u_loop_ctrl (
    .clk             (clk),
    .reset           (reset),
    .arm_i           (loop_arm),
    .clear_i         (loop_clear),
    .advance_i       (advance),
    .pc_i            (pc_q),
    .instr_pc_i      (instr_pc_q),
    .loop_end_addr_i (bus.loop_end_addr),
    .loop_count_i    (bus.loop_count),
    .wrap_take_o     (wrap_take),
    .wrap_addr_o     (wrap_addr),
    .loop_active_o   (loop_active)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    imem_addr   = pc_q;
    issue_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.stall) begin
          // Re-read the instruction decode is holding so the outputs stay put.
          imem_addr   = instr_pc_q;
          issue_valid = instr_valid_q;
        end else if (bus.halt) begin
          state_d = ST_HALT;
        end else if (bus.jump) begin
          pc_d = bus.jump_addr;
        end else begin
          issue_valid = 1'b1;
          pc_d        = wrap_take ? wrap_addr : pc_inc(pc_q);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_pc_q    <= imem_addr;
      instr_valid_q <= issue_valid;
    end
  end

  assign bus.imem_addr   = imem_addr;
  assign bus.instr       = bus.imem_instr;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.loop_active = loop_active;
  assign bus.halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a one-cycle-latency instruction memory model.
module tb_instr_fetch_ctrl;
  import dsp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_err = 0;
  int   n_checks = 0;

  logic [INSTR_W-1:0] mem [4096];

  instr_fetch_ctrl_if bus ();

  instr_fetch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) bus.imem_instr <= mem[bus.imem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_issue(input string tag, input logic [ADDR_W-1:0] pc,
                              input logic [INSTR_W-1:0] ins);
    chk({tag, ".valid"}, 32'(bus.instr_valid), 32'h1);
    chk({tag, ".pc"}, 32'(bus.instr_pc), 32'(pc));
    chk({tag, ".instr"}, 32'(bus.instr), 32'(ins));
  endtask

  task automatic expect_reset(input string tag);
    chk({tag, ".pc"}, 32'(bus.instr_pc), 32'h0);
    chk({tag, ".valid"}, 32'(bus.instr_valid), 32'h0);
    chk({tag, ".loop_active"}, 32'(bus.loop_active), 32'h0);
    chk({tag, ".halted"}, 32'(bus.halted), 32'h0);
    chk({tag, ".imem_addr"}, 32'(bus.imem_addr), 32'h0);
  endtask

  logic [ADDR_W-1:0] loop_pc  [7];
  logic              loop_act [7];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {4'h5, 12'(i)};
    mem[0] = 16'h7F89;
    mem[1] = 16'h0001;
    mem[2] = 16'h7E0A;
    loop_pc  = '{12'h5, 12'h6, 12'h5, 12'h6, 12'h5, 12'h6, 12'h7};
    loop_act = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    reset = 1'b1;
    bus.start = 1'b0; bus.stall = 1'b0; bus.halt = 1'b0; bus.jump = 1'b0;
    bus.jump_addr = '0; bus.loop_start = 1'b0; bus.loop_end_addr = '0; bus.loop_count = '0;
    tick(); tick();
    expect_reset("reset");

    // Start: first instruction two cycles after the pulse.
    reset = 1'b0; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    chk("start_bubble.valid", 32'(bus.instr_valid), 32'h0);
    tick(); expect_issue("fetch0", 12'h000, 16'h7F89);
    tick(); expect_issue("fetch1", 12'h001, 16'h0001);
    tick(); expect_issue("fetch2", 12'h002, 16'h7E0A);

    // Stall three cycles at instr_pc=2.
    bus.stall = 1'b1;
    tick(); expect_issue("stall_a", 12'h002, 16'h7E0A);
    chk("stall_a.imem_addr", 32'(bus.imem_addr), 32'h2);
    tick(); expect_issue("stall_b", 12'h002, 16'h7E0A);
    tick(); expect_issue("stall_c", 12'h002, 16'h7E0A);
    bus.stall = 1'b0;
    tick(); expect_issue("stall_release", 12'h003, 16'h5003);

    // Jump back to 0, then jump to 0x010 while instr_pc=2.
    bus.jump = 1'b1; bus.jump_addr = 12'h000;
    tick(); bus.jump = 1'b0;
    chk("jump0_bubble.valid", 32'(bus.instr_valid), 32'h0);
    tick(); expect_issue("rerun0", 12'h000, 16'h7F89);
    tick(); expect_issue("rerun1", 12'h001, 16'h0001);
    tick(); expect_issue("rerun2", 12'h002, 16'h7E0A);
    bus.jump = 1'b1; bus.jump_addr = 12'h010;
    tick(); bus.jump = 1'b0;
    chk("jump10_bubble.valid", 32'(bus.instr_valid), 32'h0);
    tick(); expect_issue("jump10", 12'h010, 16'h5010);

    // Address wrap at the top of program memory.
    bus.jump = 1'b1; bus.jump_addr = 12'hFFE;
    tick(); bus.jump = 1'b0;
    chk("jumpFFE_bubble.valid", 32'(bus.instr_valid), 32'h0);
    tick(); expect_issue("wrapFFE", 12'hFFE, 16'h5FFE);
    tick(); expect_issue("wrapFFF", 12'hFFF, 16'h5FFF);
    tick(); expect_issue("wrap000", 12'h000, 16'h7F89);
    tick(); tick(); tick();
    tick(); expect_issue("pre_loop4", 12'h004, 16'h5004);

    // Hardware loop, body 5..6, three iterations.
    chk("pre_loop.active", 32'(bus.loop_active), 32'h0);
    bus.loop_start = 1'b1; bus.loop_end_addr = 12'h006; bus.loop_count = 12'd3;
    for (int i = 0; i < 7; i++) begin
      tick();
      bus.loop_start = 1'b0;
      expect_issue($sformatf("loop3_%0d", i), loop_pc[i], {4'h5, loop_pc[i]});
      chk($sformatf("loop3_%0d.active", i), 32'(bus.loop_active), 32'(loop_act[i]));
    end

    // Zero count: body runs once, loop never armed.
    bus.jump = 1'b1; bus.jump_addr = 12'h004;
    tick(); bus.jump = 1'b0;
    tick(); expect_issue("cnt0_4", 12'h004, 16'h5004);
    bus.loop_start = 1'b1; bus.loop_count = 12'd0;
    tick(); bus.loop_start = 1'b0;
    expect_issue("cnt0_5", 12'h005, 16'h5005);
    chk("cnt0_5.active", 32'(bus.loop_active), 32'h0);
    tick(); expect_issue("cnt0_6", 12'h006, 16'h5006);
    tick(); expect_issue("cnt0_7", 12'h007, 16'h5007);
    chk("cnt0_7.active", 32'(bus.loop_active), 32'h0);

    // Jump and loop_start together: jump wins.
    bus.jump = 1'b1; bus.jump_addr = 12'h004;
    tick(); bus.jump = 1'b0;
    tick(); expect_issue("jl_4", 12'h004, 16'h5004);
    bus.jump = 1'b1; bus.loop_start = 1'b1; bus.loop_count = 12'd3;
    tick(); bus.jump = 1'b0; bus.loop_start = 1'b0;
    chk("jl_bubble.valid", 32'(bus.instr_valid), 32'h0);
    chk("jl_bubble.active", 32'(bus.loop_active), 32'h0);
    tick(); expect_issue("jl_4b", 12'h004, 16'h5004);

    // Arm a loop, then reset in the middle of it.
    bus.loop_start = 1'b1; bus.loop_count = 12'd2;
    tick(); bus.loop_start = 1'b0;
    expect_issue("ml_5", 12'h005, 16'h5005);
    chk("ml_5.active", 32'(bus.loop_active), 32'h1);
    tick(); expect_issue("ml_6", 12'h006, 16'h5006);
    tick(); expect_issue("ml_5b", 12'h005, 16'h5005);
    chk("ml_5b.active", 32'(bus.loop_active), 32'h1);
    reset = 1'b1;
    tick(); reset = 1'b0;
    expect_reset("midloop_reset");
    tick(); tick();
    expect_reset("idle_hold");

    // Halt is ignored under stall, then sticks until reset.
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    tick(); expect_issue("h_0", 12'h000, 16'h7F89);
    tick(); expect_issue("h_1", 12'h001, 16'h0001);
    bus.halt = 1'b1; bus.stall = 1'b1;
    tick(); bus.stall = 1'b0;
    expect_issue("h_stalled", 12'h001, 16'h0001);
    chk("h_stalled.halted", 32'(bus.halted), 32'h0);
    tick(); bus.halt = 1'b0;
    chk("halt.halted", 32'(bus.halted), 32'h1);
    chk("halt.valid", 32'(bus.instr_valid), 32'h0);
    bus.jump = 1'b1; bus.jump_addr = 12'h020; bus.start = 1'b1;
    tick(); bus.jump = 1'b0; bus.start = 1'b0;
    chk("halt_hold1.halted", 32'(bus.halted), 32'h1);
    chk("halt_hold1.valid", 32'(bus.instr_valid), 32'h0);
    tick(); tick();
    chk("halt_hold2.halted", 32'(bus.halted), 32'h1);
    chk("halt_hold2.valid", 32'(bus.instr_valid), 32'h0);
    reset = 1'b1;
    tick(); reset = 1'b0;
    expect_reset("halt_reset");

    // Reset in the middle of a stall.
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    tick(); tick(); expect_issue("s_1", 12'h001, 16'h0001);
    bus.stall = 1'b1;
    tick(); expect_issue("s_hold", 12'h001, 16'h0001);
    reset = 1'b1;
    tick(); reset = 1'b0; bus.stall = 1'b0;
    expect_reset("midstall_reset");
    tick();
    expect_reset("midstall_idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
